// File: rtl/mem_access_unit.sv
// Registered MEM stage: issues loads/stores over a req/ack port, builds big-endian byte lanes,
// extends load data, stalls while busy and reports misalignment and bus timeouts.
module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [3:0]            ex_mem_op,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [31:0]           ex_wdata,
  input  logic [ADDR_W-1:0]     ex_mem_addr,
  input  logic [31:0]           ex_store_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [3:0]            mem_sel,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  stall_req,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [31:0]           wb_wdata,
  output logic                  exc_adel,
  output logic                  exc_ades,
  output logic                  exc_bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [3:0]            r_op;
  logic [1:0]            r_lo;
  logic [REG_ADDR_W-1:0] r_wd;
  logic                  r_wreg;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misaligned;
  logic        w_issue;
  logic        w_timeout;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_is_load    = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LW);
  assign w_is_store   = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);
  assign w_is_mem     = w_is_load || w_is_store;
  assign w_is_half    = (ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH);
  assign w_is_word    = (ex_mem_op == OP_LW) || (ex_mem_op == OP_SW);
  assign w_misaligned = (w_is_half && ex_mem_addr[0]) || (w_is_word && (ex_mem_addr[1:0] != 2'b00));

  assign w_issue   = (r_state == S_IDLE) && ex_valid && w_is_mem && !w_misaligned;
  // Timeout releases the pipeline in the same cycle the FSM gives up.
  assign w_timeout = (r_state == S_BUSY) && !mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign stall_req = w_issue || ((r_state == S_BUSY) && !mem_ack && !w_timeout);

  always_comb begin
    w_sel   = 4'b1111;
    w_wdata = ex_store_data;
    if (w_is_word) begin
      w_sel   = 4'b1111;
      w_wdata = ex_store_data;
    end else if (w_is_half) begin
      w_sel   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
      w_wdata = {2{ex_store_data[15:0]}};
    end else begin
      w_sel   = 4'b1000 >> ex_mem_addr[1:0];
      w_wdata = {4{ex_store_data[7:0]}};
    end
  end

  // Big-endian: byte offset 0 lives in bits 31:24.
  always_comb begin
    w_byte = mem_rdata[31:24];
    case (r_lo)
      2'd0:    w_byte = mem_rdata[31:24];
      2'd1:    w_byte = mem_rdata[23:16];
      2'd2:    w_byte = mem_rdata[15:8];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (r_op)
      OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load = {24'd0, w_byte};
      OP_LH:   w_load = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_lo      <= '0;
      r_wd      <= '0;
      r_wreg    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_sel   <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_wd     <= '0;
      wb_wreg   <= 1'b0;
      wb_wdata  <= '0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
      exc_bus   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      exc_bus  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex_valid) begin
            if (!w_is_mem) begin
              wb_valid <= 1'b1;
              wb_wd    <= ex_wd;
              wb_wreg  <= ex_wreg;
              wb_wdata <= ex_wdata;
            end else if (w_misaligned) begin
              wb_valid <= 1'b1;
              wb_wd    <= ex_wd;
              wb_wreg  <= 1'b0;
              wb_wdata <= '0;
              exc_adel <= w_is_load;
              exc_ades <= w_is_store;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= w_is_store;
              mem_addr  <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
              mem_sel   <= w_sel;
              mem_wdata <= w_wdata;
              r_op      <= ex_mem_op;
              r_lo      <= ex_mem_addr[1:0];
              r_wd      <= ex_wd;
              r_wreg    <= ex_wreg;
              r_cnt     <= '0;
              r_state   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (mem_ack || w_timeout) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wb_valid <= 1'b1;
            wb_wd    <= r_wd;
            wb_wreg  <= mem_ack && r_wreg && !mem_we;
            wb_wdata <= (mem_ack && !mem_we) ? w_load : 32'd0;
            exc_bus  <= !mem_ack;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against an arithmetic reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_req;
  logic        wb_valid;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        exc_adel;
  logic        exc_ades;
  logic        exc_bus;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_op(ex_mem_op), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_wdata(ex_wdata), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_req(stall_req), .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at a later falling edge with the write-back checked.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] d,
                        input logic [4:0] wd, input logic wreg, input int ack_dly,
                        input logic [31:0] rdata, output int n_stall);
    bit          is_load, is_store, mis, acked;
    int          size, lo;
    logic [3:0]  e_sel;
    logic [31:0] e_wdata, e_load;
    is_load  = (op >= 1) && (op <= 5);
    is_store = (op >= 6) && (op <= 8);
    size     = (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : 4;
    lo       = int'(addr % 4);
    mis      = (is_load || is_store) && ((addr % size) != 0);
    if (size == 1) begin
      e_sel   = 4'b1000 >> lo;
      e_wdata = (d & 32'hFF) * 32'h0101_0101;
      e_load  = (rdata >> (8 * (3 - lo))) & 32'hFF;
      if (op == 1 && e_load >= 32'd128) e_load = e_load - 32'd256;
    end else if (size == 2) begin
      e_sel   = (lo == 0) ? 4'b1100 : 4'b0011;
      e_wdata = (d & 32'hFFFF) * 32'h0001_0001;
      e_load  = (rdata >> (8 * (2 - lo))) & 32'hFFFF;
      if (op == 3 && e_load >= 32'd32768) e_load = e_load - 32'd65536;
    end else begin
      e_sel   = 4'b1111;
      e_wdata = d;
      e_load  = rdata;
    end
    n_stall       = 0;
    acked         = 1'b0;
    ex_valid      = 1'b1;
    ex_mem_op     = op;
    ex_wd         = wd;
    ex_wreg       = wreg;
    ex_wdata      = d;
    ex_mem_addr   = addr;
    ex_store_data = d;
    mem_ack       = 1'b0;
    #1;
    if (!(is_load || is_store) || mis) begin
      chk("stall_single", stall_req, 0);
      @(negedge clk);
      ex_valid = 1'b0;
      chk("wb_valid_single", wb_valid, 1);
      chk("wb_wd_single", wb_wd, wd);
      chk("wb_wreg_single", wb_wreg, mis ? 1'b0 : wreg);
      if (!mis) chk("wb_wdata_none", wb_wdata, d);
      chk("exc_adel", exc_adel, mis && is_load);
      chk("exc_ades", exc_ades, mis && is_store);
      chk("exc_bus_single", exc_bus, 0);
      chk("mem_req_single", mem_req, 0);
    end else begin
      chk("stall_issue", stall_req, 1);
      n_stall++;
      for (int k = 1; k <= TO; k++) begin
        @(negedge clk);
        chk("mem_req_busy", mem_req, 1);
        chk("mem_we", mem_we, is_store);
        chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("mem_sel", mem_sel, e_sel);
        if (is_store) chk("mem_wdata", mem_wdata, e_wdata);
        chk("wb_valid_busy", wb_valid, 0);
        if (k == ack_dly + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
          acked     = 1'b1;
          #1;
          chk("stall_ack", stall_req, 0);
          break;
        end
        #1;
        if (k == TO) chk("stall_timeout", stall_req, 0);
        else begin
          chk("stall_busy", stall_req, 1);
          n_stall++;
        end
      end
      @(negedge clk);
      mem_ack  = 1'b0;
      ex_valid = 1'b0;
      chk("wb_valid_mem", wb_valid, 1);
      chk("wb_wd_mem", wb_wd, wd);
      chk("wb_wreg_mem", wb_wreg, acked && is_load && wreg);
      if (acked && is_load) chk("wb_wdata_load", wb_wdata, e_load);
      chk("exc_bus", exc_bus, !acked);
      chk("exc_adel_mem", exc_adel, 0);
      chk("mem_req_done", mem_req, 0);
    end
  endtask

  task automatic idle_cycle(input logic stray_ack);
    ex_valid = 1'b0;
    mem_ack  = stray_ack;
    #1;
    chk("stall_idle", stall_req, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("wb_valid_idle", wb_valid, 0);
    chk("mem_req_idle", mem_req, 0);
  endtask

  initial begin
    int ns;
    logic [3:0]  r_op;
    logic [31:0] r_addr;
    rst = 1'b1;
    ex_valid = 1'b0; ex_mem_op = 4'd0; ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'd0;
    ex_mem_addr = 32'd0; ex_store_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    chk("rst_mem_sel", mem_sel, 0);
    chk("rst_exc", {exc_adel, exc_ades, exc_bus}, 0);
    chk("rst_stall", stall_req, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(4'd0, 32'h0, 32'h1234_5678, 5'd5, 1'b1, 0, 32'h0, ns);
    run_op(4'd1, 32'h103, 32'h0, 5'd7, 1'b1, 2, 32'h0000_0080, ns);
    chk("lb_stall_cycles", ns, 3);
    run_op(4'd2, 32'h103, 32'h0, 5'd7, 1'b1, 2, 32'h0000_0080, ns);
    run_op(4'd7, 32'h202, 32'h0000_ABCD, 5'd3, 1'b1, 0, 32'h0, ns);
    run_op(4'd5, 32'h102, 32'h0, 5'd4, 1'b1, 0, 32'h0, ns);
    run_op(4'd8, 32'h101, 32'h55, 5'd4, 1'b1, 0, 32'h0, ns);
    run_op(4'd5, 32'h104, 32'h0, 5'd9, 1'b1, 100, 32'hDEAD_BEEF, ns);
    chk("timeout_stall_cycles", ns, TO);
    run_op(4'd5, 32'h108, 32'h0, 5'd9, 1'b1, TO - 1, 32'hCAFE_F00D, ns);
    run_op(4'd3, 32'h10A, 32'h0, 5'd2, 1'b1, 1, 32'h1234_8001, ns);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Abort in the third busy cycle.
    ex_valid = 1'b1; ex_mem_op = 4'd5; ex_mem_addr = 32'h300; ex_wd = 5'd1; ex_wreg = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", mem_req, 1);
    rst = 1'b1;
    ex_valid = 1'b0;
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_abort_wb_valid", wb_valid, 0);
    chk("rst_abort_mem_req", mem_req, 0);

    for (int i = 0; i < 80; i++) begin
      r_op   = 4'($urandom_range(0, 15));
      r_addr = $urandom;
      run_op(r_op, r_addr, $urandom, 5'($urandom), 1'($urandom),
             $urandom_range(0, TO + 1), $urandom, ns);
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
